// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared definitions for the UART MMIO controller: register offsets, STATUS
// and CTRL bit positions, and the TX sequencer state encoding.
package uart_mmio_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RXCNT  = 2'd3;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_AVAIL    = 2;
  localparam int ST_RX_FULL     = 3;
  localparam int ST_TX_BUSY_ANY = 4;
  localparam int ST_RX_OVERRUN  = 5;
  localparam int ST_TX_OVERFLOW = 6;

  localparam int CTRL_RX_IRQ_EN       = 0;
  localparam int CTRL_TX_EMPTY_IRQ_EN = 1;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_mmio_ctrl_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports: clk, rst (async, active high), push/din write side, pop/dout read
// side (dout shows the head entry whenever not empty), full, empty, count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: MMIO front end for the uart_tx / uart_rx byte engines.
// Ports: clk, rst (async, active high); mmio_en/we/addr/wdata request and
// mmio_rdata/mmio_rvalid response (one cycle after a read); tx_data/tx_start
// to uart_tx with tx_busy back; rx_data/rx_data_ready from uart_rx; irq.
//
// TX sequencer states:
//   state        | meaning
//   TX_IDLE      | waiting for a queued byte and uart_tx idle; pops into tx_data
//   TX_START     | tx_start asserted for this single cycle
//   TX_WAIT_BUSY | waiting for uart_tx to report busy
//   TX_WAIT_DONE | waiting for uart_tx to finish the frame
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_en,
  input  logic        mmio_we,
  input  logic [1:0]  mmio_addr,
  input  logic [15:0] mmio_wdata,
  output logic [15:0] mmio_rdata,
  output logic        mmio_rvalid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_ready,
  output logic        irq
);

  tx_state_t        state, state_nxt;
  logic [1:0]       ctrl;
  logic             rx_overrun, tx_overflow;
  logic [7:0]       tx_dout, rx_dout;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic             rd_req, wr_req;
  logic             tx_push, tx_pop, rx_push, rx_pop;
  logic             wr_data, wr_status, wr_ctrl;
  logic [6:0]       status;
  logic [15:0]      rd_mux;

  assign rd_req    = mmio_en & ~mmio_we;
  assign wr_req    = mmio_en & mmio_we;
  assign wr_data   = wr_req & (mmio_addr == REG_DATA);
  assign wr_status = wr_req & (mmio_addr == REG_STATUS);
  assign wr_ctrl   = wr_req & (mmio_addr == REG_CTRL);

  // A full TX FIFO drops the write even if the sequencer pops this cycle.
  assign tx_push = wr_data & ~tx_full;
  assign tx_pop  = (state == TX_IDLE) & ~tx_empty & ~tx_busy;
  assign rx_pop  = rd_req & (mmio_addr == REG_DATA) & ~rx_empty;
  assign rx_push = rx_data_ready & (~rx_full | rx_pop);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(mmio_wdata[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_data),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign status = {tx_overflow, rx_overrun, (state != TX_IDLE) | ~tx_empty,
                   rx_full, ~rx_empty, tx_empty, tx_full};

  always_comb begin
    rd_mux = '0;
    case (mmio_addr)
      REG_DATA:   if (!rx_empty) rd_mux[7:0] = rx_dout;
      REG_STATUS: rd_mux[6:0] = status;
      REG_CTRL:   rd_mux[1:0] = ctrl;
      default:    rd_mux[CNT_W-1:0] = rx_count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:      if (tx_pop) state_nxt = TX_START;
      TX_START:     state_nxt = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (tx_busy) state_nxt = TX_WAIT_DONE;
      default:      if (!tx_busy) state_nxt = TX_IDLE;
    endcase
  end

  assign tx_start = (state == TX_START);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= TX_IDLE;
      tx_data     <= '0;
      ctrl        <= '0;
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
      mmio_rdata  <= '0;
      mmio_rvalid <= 1'b0;
      irq         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (tx_pop) tx_data <= tx_dout;
      if (wr_ctrl) ctrl <= mmio_wdata[1:0];
      // Set has priority over a same-cycle write-one-to-clear.
      rx_overrun  <= (rx_data_ready & rx_full & ~rx_pop) |
                     (rx_overrun & ~(wr_status & mmio_wdata[ST_RX_OVERRUN]));
      tx_overflow <= (wr_data & tx_full) |
                     (tx_overflow & ~(wr_status & mmio_wdata[ST_TX_OVERFLOW]));
      mmio_rvalid <= rd_req;
      mmio_rdata  <= rd_req ? rd_mux : 16'h0000;
      irq <= (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty) |
             (ctrl[CTRL_TX_EMPTY_IRQ_EN] & tx_empty & (state == TX_IDLE));
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
module tb_uart_mmio_ctrl;
  import uart_mmio_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_en = 1'b0;
  logic        mmio_we = 1'b0;
  logic [1:0]  mmio_addr = 2'd0;
  logic [15:0] mmio_wdata = 16'h0000;
  logic [15:0] mmio_rdata;
  logic        mmio_rvalid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_ready = 1'b0;
  logic        irq;

  int n_chk = 0;
  int n_pass = 0;

  uart_mmio_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .mmio_en(mmio_en), .mmio_we(mmio_we),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .mmio_rvalid(mmio_rvalid), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: goes busy when it sees tx_start, stays busy busy_len cycles.
  logic [7:0] tx_log[$];
  int         tx_t[$];
  int         busy_len = 100;
  bit         busy_stuck = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] cur_byte = 8'h00;
  int         hold_err = 0;

  always @(negedge clk) begin
    if (tx_start) begin
      tx_log.push_back(tx_data);
      tx_t.push_back(cyc);
      cur_byte = tx_data;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      if (tx_data !== cur_byte) hold_err++;
      busy_cnt--;
    end
    tx_busy = busy_stuck || (busy_cnt > 0);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    mmio_en = 1'b1; mmio_we = 1'b1; mmio_addr = a; mmio_wdata = d;
    @(negedge clk);
    mmio_en = 1'b0; mmio_we = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [15:0] exp, input string tag);
    mmio_en = 1'b1; mmio_we = 1'b0; mmio_addr = a;
    @(negedge clk);
    mmio_en = 1'b0;
    chk({tag, "_rvalid"}, 16'(mmio_rvalid), 16'h0001);
    chk(tag, mmio_rdata, exp);
  endtask

  task automatic rx_inject(input logic [7:0] b);
    rx_data = b; rx_data_ready = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int i = 0; i < budget && tx_log.size() < n; i++) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rdata", mmio_rdata, 16'h0000);
    chk("rst_rvalid", 16'(mmio_rvalid), 16'h0000);
    chk("rst_tx_data", 16'(tx_data), 16'h0000);
    chk("rst_tx_start", 16'(tx_start), 16'h0000);
    chk("rst_irq", 16'(irq), 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    rd_chk(REG_STATUS, 16'h0002, "status_after_reset");
    rd_chk(REG_RXCNT, 16'h0000, "rxcnt_after_reset");
    rd_chk(REG_DATA, 16'h0000, "rx_empty_read");

    // Three bytes back-to-back, 100-cycle busy per byte
    wr(REG_DATA, 16'h0041);
    wr(REG_DATA, 16'h0042);
    wr(REG_DATA, 16'h0043);
    wait_starts(3, 1000);
    repeat (110) @(negedge clk);
    chk("tx3_count", 16'(tx_log.size()), 16'd3);
    if (tx_log.size() == 3) begin
      chk("tx3_byte0", 16'(tx_log[0]), 16'h0041);
      chk("tx3_byte1", 16'(tx_log[1]), 16'h0042);
      chk("tx3_byte2", 16'(tx_log[2]), 16'h0043);
      chk("tx3_gap01", 16'(tx_t[1] - tx_t[0] > busy_len), 16'h0001);
      chk("tx3_gap12", 16'(tx_t[2] - tx_t[1] > busy_len), 16'h0001);
    end
    rd_chk(REG_STATUS, 16'h0002, "status_tx_done");

    // Overflow with uart_tx stuck busy
    busy_stuck = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 9; i++) wr(REG_DATA, 16'(i));
    rd_chk(REG_STATUS, 16'h0051, "status_tx_overflow");
    wr(REG_STATUS, 16'h0040);
    rd_chk(REG_STATUS, 16'h0011, "status_ovf_w1c");
    tx_log.delete();
    tx_t.delete();
    busy_stuck = 1'b0;
    wait_starts(8, 2000);
    repeat (110) @(negedge clk);
    chk("drain_count", 16'(tx_log.size()), 16'd8);
    for (int i = 0; i < 8 && i < tx_log.size(); i++)
      chk($sformatf("drain_byte%0d", i), 16'(tx_log[i]), 16'(i + 1));
    chk("tx_data_hold", 16'(hold_err), 16'd0);
    rd_chk(REG_STATUS, 16'h0002, "status_drained");

    // RX overrun: 9 bytes into an 8-deep FIFO
    for (int i = 0; i < 9; i++) rx_inject(8'(8'h10 + i));
    rd_chk(REG_RXCNT, 16'd8, "rxcnt_full");
    rd_chk(REG_STATUS, 16'h002E, "status_rx_overrun");
    for (int i = 0; i < 8; i++) rd_chk(REG_DATA, 16'(16'h0010 + i), $sformatf("rx_byte%0d", i));
    rd_chk(REG_DATA, 16'h0000, "rx_read_empty");
    wr(REG_STATUS, 16'h0020);
    rd_chk(REG_STATUS, 16'h0002, "status_ovr_w1c");

    // Push and pop in the same cycle while RX full
    for (int i = 0; i < 8; i++) rx_inject(8'(8'h20 + i));
    rx_data = 8'h55; rx_data_ready = 1'b1;
    mmio_en = 1'b1; mmio_we = 1'b0; mmio_addr = REG_DATA;
    @(negedge clk);
    rx_data_ready = 1'b0; mmio_en = 1'b0;
    chk("simfull_rvalid", 16'(mmio_rvalid), 16'h0001);
    chk("simfull_rdata", mmio_rdata, 16'h0020);
    rd_chk(REG_RXCNT, 16'd8, "simfull_rxcnt");
    rd_chk(REG_STATUS, 16'h000E, "simfull_status");
    for (int i = 1; i < 8; i++) rd_chk(REG_DATA, 16'(16'h0020 + i), $sformatf("simfull_byte%0d", i));
    rd_chk(REG_DATA, 16'h0055, "simfull_last");

    // Push and read in the same cycle while RX empty: no bypass
    rx_data = 8'h66; rx_data_ready = 1'b1;
    mmio_en = 1'b1; mmio_we = 1'b0; mmio_addr = REG_DATA;
    @(negedge clk);
    rx_data_ready = 1'b0; mmio_en = 1'b0;
    chk("simempty_rvalid", 16'(mmio_rvalid), 16'h0001);
    chk("simempty_rdata", mmio_rdata, 16'h0000);
    rd_chk(REG_RXCNT, 16'd1, "simempty_rxcnt");
    rd_chk(REG_DATA, 16'h0066, "simempty_byte");

    // Unmapped write ignored, CTRL readback masks unused bits
    wr(REG_RXCNT, 16'h00FF);
    rd_chk(REG_RXCNT, 16'd0, "rxcnt_write_ignored");
    wr(REG_CTRL, 16'hFFFC);
    rd_chk(REG_CTRL, 16'h0000, "ctrl_mask");

    // Interrupts
    wr(REG_CTRL, 16'h0001);
    rd_chk(REG_CTRL, 16'h0001, "ctrl_rx_en");
    rx_inject(8'h7E);
    chk("irq_push_cycle", 16'(irq), 16'h0000);
    @(negedge clk);
    chk("irq_rise", 16'(irq), 16'h0001);
    rd_chk(REG_DATA, 16'h007E, "irq_rx_byte");
    chk("irq_hold_at_pop", 16'(irq), 16'h0001);
    @(negedge clk);
    chk("irq_fall", 16'(irq), 16'h0000);
    wr(REG_CTRL, 16'h0002);
    @(negedge clk);
    chk("irq_tx_empty", 16'(irq), 16'h0001);
    wr(REG_CTRL, 16'h0000);
    @(negedge clk);
    chk("irq_disabled", 16'(irq), 16'h0000);

    // Reset while a byte is in flight with 3 more queued
    tx_log.delete();
    tx_t.delete();
    wr(REG_DATA, 16'h00A1);
    wr(REG_DATA, 16'h00A2);
    wr(REG_DATA, 16'h00A3);
    wr(REG_DATA, 16'h00A4);
    repeat (10) @(negedge clk);
    rd_chk(REG_STATUS, 16'h0010, "status_mid_byte");
    chk("mid_tx_data", 16'(tx_data), 16'h00A1);
    tx_log.delete();
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx_data", 16'(tx_data), 16'h0000);
    chk("midrst_tx_start", 16'(tx_start), 16'h0000);
    chk("midrst_irq", 16'(irq), 16'h0000);
    chk("midrst_rdata", mmio_rdata, 16'h0000);
    chk("midrst_rvalid", 16'(mmio_rvalid), 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_chk(REG_STATUS, 16'h0002, "status_after_midrst");
    repeat (200) @(negedge clk);
    chk("no_start_after_rst", 16'(tx_log.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Memory-mapped UART controller between the CPU MMIO bus and the existing uart_tx / uart_rx byte engines.
- Buffers outgoing bytes in a TX FIFO and sequences uart_tx one byte at a time.
- Captures received bytes into an RX FIFO.
- Exposes DATA / STATUS / CTRL registers and a level interrupt to the CPU.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO; power of two, at least 2
- CNT_W, $clog2(FIFO_DEPTH)+1, FIFO occupancy counter width

Ports:
- clk  in  1  system clock (50 MHz domain)
- rst  in  1  asynchronous, active-high reset
- mmio_en  in  1  single-cycle bus request strobe
- mmio_we  in  1  1 = write, 0 = read; sampled with mmio_en
- mmio_addr  in  2  register offset
- mmio_wdata  in  16  write data
- mmio_rdata  out  16  read data, valid when mmio_rvalid
- mmio_rvalid  out  1  one-cycle pulse, exactly 1 cycle after a read request
- tx_data  out  8  byte to uart_tx, held stable from tx_start until busy falls
- tx_start  out  1  one-cycle start pulse to uart_tx
- tx_busy  in  1  uart_tx busy / not-idle
- rx_data  in  8  byte from uart_rx
- rx_data_ready  in  1  one-cycle pulse from uart_rx
- irq  out  1  level interrupt

Behaviour:
- Reset (asynchronous): both FIFOs empty; CTRL = 0; sticky bits cleared; TX FSM in TX_IDLE. All outputs 0: mmio_rdata, mmio_rvalid, tx_data, tx_start, irq.
- Register map (offset -> register):
  - 0 DATA. Write pushes wdata[7:0] to the TX FIFO. Read pops the RX FIFO and returns {8'h00, byte}; returns 16'h0000 with no pop when empty.
  - 1 STATUS (read-only bits 0..4):
    - [0] tx_full, [1] tx_empty, [2] rx_avail, [3] rx_full, [4] tx_busy_any (FSM not idle or FIFO non-empty).
    - [5] rx_overrun, sticky. [6] tx_overflow, sticky.
    - Writing 1 to bit 5 or bit 6 clears that bit.
    - [15:7] read as 0.
  - 2 CTRL (R/W): [0] rx_irq_en, [1] tx_empty_irq_en; other bits read as 0.
  - 3 RX_COUNT (read-only): RX occupancy in [CNT_W-1:0].
- Unmapped writes are ignored.
- TX full write: byte dropped; tx_overflow set.
- RX push while full (no simultaneous pop): byte dropped; rx_overrun set.
- Simultaneous rx_data_ready and DATA read while RX full: pop and push both happen; no overrun; count unchanged.
- Simultaneous rx_data_ready and DATA read while RX empty: the read returns 0; the byte is pushed (no bypass).
- Sticky-bit set and W1C clear in the same cycle: set wins.
- TX FSM:
  - TX_IDLE: if TX FIFO non-empty and tx_busy == 0, pop the FIFO into tx_data -> TX_START.
  - TX_START: tx_start = 1 for exactly this cycle -> TX_WAIT_BUSY.
  - TX_WAIT_BUSY: wait for tx_busy == 1 -> TX_WAIT_DONE.
  - TX_WAIT_DONE: wait for tx_busy == 0 -> TX_IDLE.
  - Minimum gap between tx_start pulses: 4 cycles plus the busy period. Bytes go out in FIFO order.
- A TX push in the same cycle as the TX_IDLE pop is legal; occupancy is net-updated.
- irq = (rx_irq_en & rx_avail) | (tx_empty_irq_en & tx_empty & FSM in TX_IDLE). Registered, so 1 cycle of latency.
- Reset asserted mid-byte: FSM returns to idle and FIFOs flush. uart_tx finishing its frame is tolerated; no new start is issued until busy has been observed low in TX_IDLE.

Decomposition:
- Package uart_mmio_pkg:
  - Register offsets REG_DATA = 0, REG_STATUS = 1, REG_CTRL = 2, REG_RXCNT = 3.
  - STATUS bit index constants.
  - CTRL bit index constants.
  - tx_state_t enum {TX_IDLE, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE}.
- Sub-module sync_fifo (WIDTH = 8, DEPTH = FIFO_DEPTH), instantiated twice (TX and RX).
  - Ports: push, pop, din, dout (first-word-fall-through), full, empty, count.
  - Simultaneous push and pop are allowed when full.

Test Plan:
- Write DATA 0x41, 0x42, 0x43 back-to-back, with a uart_tx model holding busy 100 cycles -> three tx_start pulses with tx_data 0x41, 0x42, 0x43 in order; STATUS[1] = 1 afterwards.
- Write 9 bytes with tx_busy stuck high and FIFO_DEPTH = 8 -> bytes 1..8 buffered; STATUS = tx_full | tx_overflow. W1C 0x0040 clears bit 6 only.
- Inject 9 RX bytes 0x10..0x18 with no reads -> RX_COUNT = 8, rx_overrun = 1; reads return 0x0010..0x0017, then 0x0000 with rvalid = 1.
- RX full, then rx_data_ready 0x55 in the same cycle as a DATA read -> read returns the oldest byte; RX_COUNT stays 8; rx_overrun stays 0; 0x55 is returned last.
- CTRL = 0x0001, inject byte 0x7E -> irq rises 1 cycle after the push and falls 1 cycle after the DATA read empties the FIFO. CTRL = 0x0002 with idle TX -> irq = 1.
- Assert rst while in TX_WAIT_DONE with 3 bytes queued -> all outputs 0 immediately; after release STATUS = 0x0002 and no tx_start is issued.
